npr_arbiter: RTL and testbench

Round-robin arbiter that shares the single Unibus NPR (DMA) master port among up to `NREQ` device requesters, such as the KMC11 NPR control logic and sibling devices. Each device raises a level request and waits for a one-cycle acknowledge. The arbiter serialises these requests onto one bus request/acknowledge pair and returns the acknowledge to the winning device. It sits between the device NPR controllers and the UBA DMA interface. It steers the address and data mux through `grantIDX` and enforces a hold-time watchdog so one device cannot own the bus indefinitely.

---
 rtl/npr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_npr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/npr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : npr_arbiter
// Description : Round-robin arbiter sharing the single Unibus NPR (DMA)
//               master port among NREQ device requesters. Serialises level
//               requests onto one bus request/acknowledge pair, returns a
//               one-cycle acknowledge to the winner, steers the address/data
//               mux via grantIDX and forces a release when a granted device
//               keeps the bus longer than MAXHOLD cycles.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               arbINIT       - synchronous clear, same effect as rst
//               devREQI[N]    - level NPR request per device
//               devACKO[N]    - one-cycle acknowledge to the winning device
//               busREQO       - NPR request to the UBA
//               busACKI       - UBA acknowledge (only honoured in BUSREQ)
//               grantVLD      - grant in progress (BUSREQ through HOLD)
//               grantIDX      - current / most recent winner, mux select
//               arbTMO        - one-cycle pulse on a watchdog release
// Revision    : 1.0 - initial release
// ============================================================================
module npr_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [11:0] MAXHOLD = 12'd1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arbINIT,
  input  logic [NREQ-1:0]         devREQI,
  output logic [NREQ-1:0]         devACKO,
  output logic                    busREQO,
  input  logic                    busACKI,
  output logic                    grantVLD,
  output logic [$clog2(NREQ)-1:0] grantIDX,
  output logic                    arbTMO
);

  localparam int                IDX_W      = $clog2(NREQ);
  localparam logic [IDX_W-1:0]  c_LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [IDX_W:0]    c_NREQ     = (IDX_W + 1)'(NREQ);
  localparam logic [NREQ-1:0]   c_ACK_ONE  = {{(NREQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSREQ  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [IDX_W-1:0]  last_q,      last_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [11:0]       cnt_q,       cnt_d;
  logic [NREQ-1:0]   dev_ack_q,   dev_ack_d;
  logic              bus_req_q,   bus_req_d;
  logic              grant_vld_q, grant_vld_d;
  logic              tmo_q,       tmo_d;

  // Round-robin winner search: first set request at last+1, last+2, ...
  // wrapping modulo NREQ. last+i never exceeds 2*NREQ-1, so one
  // conditional subtract is enough for the wrap even when NREQ is not a
  // power of two.
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    scan_sum;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_sum = {1'b0, last_q} + (IDX_W + 1)'(i);
      if (scan_sum >= c_NREQ) begin
        scan_sum = scan_sum - c_NREQ;
      end
      if (!win_found && devREQI[scan_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arbINIT) begin
      state_q     <= IDLE;
      last_q      <= c_LAST_RST;
      grant_idx_q <= '0;
      cnt_q       <= MAXHOLD;
      dev_ack_q   <= '0;
      bus_req_q   <= 1'b0;
      grant_vld_q <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_idx_q <= grant_idx_d;
      cnt_q       <= cnt_d;
      dev_ack_q   <= dev_ack_d;
      bus_req_q   <= bus_req_d;
      grant_vld_q <= grant_vld_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_idx_d = grant_idx_q;
    cnt_d       = cnt_q;
    dev_ack_d   = '0;
    bus_req_d   = bus_req_q;
    grant_vld_d = grant_vld_q;
    tmo_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_idx_d = win_idx;
          last_d      = win_idx;
          bus_req_d   = 1'b1;
          grant_vld_d = 1'b1;
          state_d     = BUSREQ;
        end
      end

      BUSREQ: begin
        // A device abandoning its request wins over a simultaneous bus ack,
        // so it is never acknowledged for a transfer it has given up on.
        if (!devREQI[grant_idx_q]) begin
          bus_req_d   = 1'b0;
          grant_vld_d = 1'b0;
          state_d     = RELEASE;
        end else if (busACKI) begin
          dev_ack_d   = c_ACK_ONE << grant_idx_q;
          cnt_d       = MAXHOLD;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (!devREQI[grant_idx_q]) begin
          bus_req_d   = 1'b0;
          grant_vld_d = 1'b0;
          state_d     = RELEASE;
        end else if (cnt_q == 12'd0) begin
          tmo_d       = 1'b1;
          bus_req_d   = 1'b0;
          grant_vld_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          cnt_d       = cnt_q - 12'd1;
        end
      end

      // One dead cycle so the UBA always sees busREQO low between grants.
      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign devACKO  = dev_ack_q;
  assign busREQO  = bus_req_q;
  assign grantVLD = grant_vld_q;
  assign grantIDX = grant_idx_q;
  assign arbTMO   = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_npr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_npr_arbiter
// Description : Self-checking bench for npr_arbiter (NREQ=4, MAXHOLD=10).
//               Directed scenarios push expected grant / acknowledge /
//               timeout events into a queue; a negedge monitor pops and
//               compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npr_arbiter;

  localparam int          NREQ    = 4;
  localparam logic [11:0] MAXHOLD = 12'd10;

  localparam int EV_GRANT = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_TMO   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            arbINIT;
  logic [NREQ-1:0] devREQI;
  logic [NREQ-1:0] devACKO;
  logic            busREQO;
  logic            busACKI;
  logic            grantVLD;
  logic [1:0]      grantIDX;
  logic            arbTMO;

  npr_arbiter #(
    .NREQ    (NREQ),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arbINIT  (arbINIT),
    .devREQI  (devREQI),
    .devACKO  (devACKO),
    .busREQO  (busREQO),
    .busACKI  (busACKI),
    .grantVLD (grantVLD),
    .grantIDX (grantIDX),
    .arbTMO   (arbTMO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } evt_t;

  evt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
    end
  endtask

  task automatic push_evt(input int kind, input logic [31:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [31:0] val);
    evt_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_evt", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      chk("sb_val", val, e.val);
    end
  endtask

  // Event monitor: a grant is grantVLD rising; busREQO must rise with it.
  always @(negedge clk) begin
    if (!rst && !arbINIT) begin
      if (grantVLD && !prev_vld) begin
        check_evt(EV_GRANT, 32'(grantIDX));
        chk("mon_busreq_at_grant", 32'(busREQO), 32'd1);
      end
      if (devACKO != '0) check_evt(EV_ACK, 32'(devACKO));
      if (arbTMO)        check_evt(EV_TMO, 32'd1);
    end
    prev_vld <= grantVLD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From BUSREQ with device idx granted: acknowledge, device drops one
  // cycle after its devACKO, return to IDLE.
  task automatic serve(input int idx);
    push_evt(EV_ACK, 32'(1) << idx);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("serve_ack", 32'(devACKO), 32'(1) << idx);
    devREQI[idx] = 1'b0;
    tick();
    chk("serve_rel_busreq", 32'(busREQO), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst     = 1'b1;
    arbINIT = 1'b0;
    devREQI = '0;
    busACKI = 1'b0;
    tick();
    tick();
    chk("rst_busREQO",  32'(busREQO),  32'd0);
    chk("rst_devACKO",  32'(devACKO),  32'd0);
    chk("rst_grantVLD", 32'(grantVLD), 32'd0);
    chk("rst_grantIDX", 32'(grantIDX), 32'd0);
    chk("rst_arbTMO",   32'(arbTMO),   32'd0);
    rst = 1'b0;
    tick();

    // Two requesters: device 0 first, then device 2.
    devREQI = 4'b0101;
    chk("s1_busreq_pre", 32'(busREQO), 32'd0);
    push_evt(EV_GRANT, 32'd0);
    tick();
    chk("s1_busreq", 32'(busREQO), 32'd1);
    chk("s1_idx",    32'(grantIDX), 32'd0);
    push_evt(EV_ACK, 32'b0001);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("s1_ack", 32'(devACKO), 32'b0001);
    devREQI = 4'b0100;
    tick();
    chk("s1_rel", 32'(busREQO), 32'd0);
    push_evt(EV_GRANT, 32'd2);
    tick();
    tick();
    chk("s1_idx2", 32'(grantIDX), 32'd2);
    serve(2);

    // Reset the pointer, then all four requesting: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_idx", 32'(grantIDX), 32'd0);
    devREQI = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      push_evt(EV_GRANT, 32'(g));
      tick();
      chk("s2_order", 32'(grantIDX), 32'(g));
      push_evt(EV_ACK, 32'(1) << g);
      busACKI = 1'b1;
      tick();
      busACKI = 1'b0;
      devREQI[g] = 1'b0;
      tick();
      chk("s2_gap", 32'(busREQO), 32'd0);
      if (k < 4) devREQI[g] = 1'b1;
      else       devREQI = '0;
      tick();
    end
    tick();

    // Device 1 abandons in BUSREQ in the same cycle busACKI rises.
    devREQI = 4'b0010;
    push_evt(EV_GRANT, 32'd1);
    tick();
    chk("s3_idx", 32'(grantIDX), 32'd1);
    busACKI = 1'b1;
    devREQI = 4'b0000;
    tick();
    busACKI = 1'b0;
    chk("s3_busreq", 32'(busREQO),  32'd0);
    chk("s3_vld",    32'(grantVLD), 32'd0);
    chk("s3_noack",  32'(devACKO),  32'd0);
    // Requests raised now must not be served before RELEASE elapses.
    devREQI = 4'b0110;
    tick();
    chk("s3_release_gap", 32'(busREQO), 32'd0);
    push_evt(EV_GRANT, 32'd2);
    tick();
    chk("s4_idx", 32'(grantIDX), 32'd2);

    // Device 2 holds past the watchdog; a stray busACKI in HOLD is ignored.
    push_evt(EV_ACK, 32'b0100);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    push_evt(EV_TMO, 32'd1);
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      busACKI = (i == 3);
      if (arbTMO) begin
        c = i;
        break;
      end
    end
    busACKI = 1'b0;
    chk("s4_tmo_latency", 32'(c), 32'd11);
    chk("s4_tmo_busreq",  32'(busREQO),  32'd0);
    chk("s4_tmo_vld",     32'(grantVLD), 32'd0);
    push_evt(EV_GRANT, 32'd1);
    tick();
    tick();
    chk("s4_next_idx", 32'(grantIDX), 32'd1);
    devREQI = 4'b0010;
    serve(1);

    // arbINIT during HOLD.
    devREQI = 4'b0001;
    push_evt(EV_GRANT, 32'd0);
    tick();
    push_evt(EV_ACK, 32'b0001);
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    tick();
    tick();
    arbINIT = 1'b1;
    tick();
    arbINIT = 1'b0;
    chk("s5_busREQO",  32'(busREQO),  32'd0);
    chk("s5_grantVLD", 32'(grantVLD), 32'd0);
    chk("s5_grantIDX", 32'(grantIDX), 32'd0);
    chk("s5_devACKO",  32'(devACKO),  32'd0);
    chk("s5_arbTMO",   32'(arbTMO),   32'd0);
    devREQI = 4'b1001;
    push_evt(EV_GRANT, 32'd0);
    tick();
    chk("s5_restart_idx", 32'(grantIDX), 32'd0);
    devREQI = 4'b0001;
    serve(0);

    // busACKI in IDLE with no requests.
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    chk("s6_noack",   32'(devACKO),  32'd0);
    chk("s6_busreq",  32'(busREQO),  32'd0);
    chk("s6_vld",     32'(grantVLD), 32'd0);
    tick();
    devREQI = 4'b0010;
    push_evt(EV_GRANT, 32'd1);
    tick();
    chk("s6_grant_busreq", 32'(busREQO),  32'd1);
    chk("s6_grant_idx",    32'(grantIDX), 32'd1);
    serve(1);
    tick();
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
